// File: rtl/debug_command_parser_pkg.sv
// Shared encodings for the debug command parser: OPX codes, error byte, FSM states.
package debug_command_parser_pkg;

  localparam logic [2:0] DEBUG_OPX_NONE     = 3'd0;
  localparam logic [2:0] DEBUG_OPX_RD_REG   = 3'd1;
  localparam logic [2:0] DEBUG_OPX_RD_CC    = 3'd2;
  localparam logic [2:0] DEBUG_OPX_RD_PC    = 3'd3;
  localparam logic [2:0] DEBUG_OPX_RD_MEM   = 3'd4;
  localparam logic [2:0] DEBUG_OPX_WR_MEM   = 3'd5;
  localparam logic [2:0] DEBUG_OPX_SET_ADDR = 3'd6;

  localparam logic [7:0] DEBUG_ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARG_LO, ST_ARG_HI, ST_EXEC, ST_WAIT, ST_RESP_LO, ST_RESP_HI
  } parser_state_t;

  function automatic logic is_rd_op(input logic [2:0] opx);
    return (opx == DEBUG_OPX_RD_REG) || (opx == DEBUG_OPX_RD_CC) ||
           (opx == DEBUG_OPX_RD_PC)  || (opx == DEBUG_OPX_RD_MEM);
  endfunction

endpackage

// File: rtl/debug_resp_tx.sv
// Response serialiser: sends word[7:0] then word[15:8], or only word[15:8] when two=0.
module debug_resp_tx (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        load,
  input  logic [15:0] word,
  input  logic        two,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);
  logic [15:0] word_q;
  logic        hi_q, vld_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      word_q <= '0;
      hi_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else if (load) begin
      word_q <= word;
      hi_q   <= ~two;
      vld_q  <= 1'b1;
    end else if (vld_q && tx_ready) begin
      if (hi_q) vld_q <= 1'b0;
      else      hi_q  <= 1'b1;
    end
  end

  // Byte select only moves on a handshake, so data stays put under back-pressure.
  assign tx_data  = hi_q ? word_q[15:8] : word_q[7:0];
  assign tx_valid = vld_q;
  assign last     = vld_q & tx_ready & hi_q;
endmodule

// File: rtl/debug_command_parser.sv
// Debug-port byte-stream parser: builds DEBUG_OP/ARGX, owns ADDR/WDATA, runs EXEC/DONE.
// Optional WAIT timeout abort enabled by defining DEBUG_PARSER_TIMEOUT_EN.
module debug_command_parser
  import debug_command_parser_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic [7:0]        TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic [3:0]        DEBUG_OP,
  output logic [3:0]        DEBUG_ARGX,
  output logic [ADDR_W-1:0] DEBUG_ADDR,
  output logic [DATA_W-1:0] DEBUG_WDATA,
  output logic              DEBUG_EXEC,
  input  logic              DEBUG_DONE,
  input  logic [DATA_W-1:0] DEBUG_RDATA,
  output logic              DEBUG_BUSY
);
  parser_state_t     state_q, state_d;
  logic [7:0]        cmd_q, arg_lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cmd_ld, lo_ld, addr_ld, wdata_ld, addr_inc;
  logic              ld, ld_two, tx_last;
  logic [15:0]       ld_word;
  logic              rx_fire, tmo_hit;
  logic [2:0]        opx_in, opx_q;

  assign opx_in  = RX_DATA[7:5];
  assign opx_q   = cmd_q[7:5];
  assign rx_fire = RX_VALID && RX_READY;

`ifdef DEBUG_PARSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Hit on the last permitted WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES.
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RESETN)                 tmo_q <= '0;
    else if (state_q == ST_EXEC) tmo_q <= '0;
    else if (state_q == ST_WAIT) tmo_q <= tmo_q + TMO_W'(1);
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cmd_ld   = 1'b0;
    lo_ld    = 1'b0;
    addr_ld  = 1'b0;
    wdata_ld = 1'b0;
    addr_inc = 1'b0;
    ld       = 1'b0;
    ld_two   = 1'b0;
    ld_word  = '0;
    case (state_q)
      ST_IDLE: if (rx_fire) begin
        if (opx_in == DEBUG_OPX_SET_ADDR || opx_in == DEBUG_OPX_WR_MEM) begin
          cmd_ld  = 1'b1;
          state_d = ST_ARG_LO;
        end else if (is_rd_op(opx_in)) begin
          cmd_ld  = 1'b1;
          state_d = ST_EXEC;
        end else begin
          ld      = 1'b1;
          ld_word = {(opx_in == DEBUG_OPX_NONE) ? RX_DATA : DEBUG_ERR_BYTE, 8'h00};
          state_d = ST_RESP_HI;
        end
      end
      ST_ARG_LO: if (rx_fire) begin
        lo_ld   = 1'b1;
        state_d = ST_ARG_HI;
      end
      ST_ARG_HI: if (rx_fire) begin
        if (opx_q == DEBUG_OPX_SET_ADDR) begin
          addr_ld = 1'b1;
          ld      = 1'b1;
          ld_word = {cmd_q, 8'h00};
          state_d = ST_RESP_HI;
        end else begin
          wdata_ld = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: if (DEBUG_DONE) begin
        addr_inc = cmd_q[4] && (opx_q == DEBUG_OPX_RD_REG || opx_q == DEBUG_OPX_RD_MEM ||
                                opx_q == DEBUG_OPX_WR_MEM);
        ld       = 1'b1;
        if (opx_q == DEBUG_OPX_WR_MEM) begin
          ld_word = {cmd_q, 8'h00};
          state_d = ST_RESP_HI;
        end else begin
          ld_word = DEBUG_RDATA;
          ld_two  = 1'b1;
          state_d = ST_RESP_LO;
        end
      end else if (tmo_hit) begin
        ld      = 1'b1;
        ld_word = {DEBUG_ERR_BYTE, 8'h00};
        state_d = ST_RESP_HI;
      end
      ST_RESP_LO: if (TX_VALID && TX_READY) state_d = ST_RESP_HI;
      ST_RESP_HI: if (tx_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      arg_lo_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_ld)   cmd_q    <= RX_DATA;
      if (lo_ld)    arg_lo_q <= RX_DATA;
      if (addr_ld)  addr_q   <= ADDR_W'({RX_DATA, arg_lo_q});
      else if (addr_inc) addr_q <= addr_q + ADDR_W'(1);
      if (wdata_ld) wdata_q  <= DATA_W'({RX_DATA, arg_lo_q});
    end
  end

  debug_resp_tx u_resp_tx (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .load     (ld),
    .word     (ld_word),
    .two      (ld_two),
    .tx_data  (TX_DATA),
    .tx_valid (TX_VALID),
    .tx_ready (TX_READY),
    .last     (tx_last)
  );

  // Decoder sees NONE (0) whenever no operation is in flight.
  assign DEBUG_OP    = (state_q == ST_EXEC || state_q == ST_WAIT) ? cmd_q[7:4] : 4'h0;
  assign DEBUG_ARGX  = (state_q == ST_EXEC || state_q == ST_WAIT) ? cmd_q[3:0] : 4'h0;
  assign DEBUG_EXEC  = (state_q == ST_EXEC);
  assign DEBUG_BUSY  = (state_q != ST_IDLE);
  assign RX_READY    = (state_q == ST_IDLE) || (state_q == ST_ARG_LO) || (state_q == ST_ARG_HI);
  assign DEBUG_ADDR  = addr_q;
  assign DEBUG_WDATA = wdata_q;
endmodule

// File: tb/tb_debug_command_parser.sv
// Scoreboard bench for debug_command_parser: expected TX bytes queued at stimulus time.
module tb_debug_command_parser;
  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic [3:0]  DEBUG_OP, DEBUG_ARGX;
  logic [15:0] DEBUG_ADDR, DEBUG_WDATA;
  logic        DEBUG_EXEC;
  logic        DEBUG_DONE = 1'b0;
  logic [15:0] DEBUG_RDATA = 16'h0000;
  logic        DEBUG_BUSY;

  int total = 0;
  int bad = 0;
  int exec_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  debug_command_parser #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .DEBUG_OP(DEBUG_OP), .DEBUG_ARGX(DEBUG_ARGX), .DEBUG_ADDR(DEBUG_ADDR),
    .DEBUG_WDATA(DEBUG_WDATA), .DEBUG_EXEC(DEBUG_EXEC), .DEBUG_DONE(DEBUG_DONE),
    .DEBUG_RDATA(DEBUG_RDATA), .DEBUG_BUSY(DEBUG_BUSY)
  );

  always #5 CLK = ~CLK;

  // TX monitor: a byte transfers on the coming edge when valid & ready here.
  always @(negedge CLK) begin
    if (RESETN && DEBUG_EXEC) exec_cnt++;
    if (RESETN && TX_VALID && TX_READY) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected got=%02h exp=none", TX_DATA);
      end else begin
        exp_b = exp_q.pop_front();
        if (TX_DATA !== exp_b) begin
          bad++;
          $display("FAIL tx_byte got=%02h exp=%02h", TX_DATA, exp_b);
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    while (!RX_READY && n < 100) begin @(negedge CLK); n++; end
    total++;
    if (!RX_READY) begin bad++; $display("FAIL rx_accept byte=%02h got=0 exp=1", b); end
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge CLK);
    while (DEBUG_BUSY && n < 300) begin @(negedge CLK); n++; end
    total++;
    if (DEBUG_BUSY || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_idle busy=%0b pending=%0d exp busy=0 pending=0", name, DEBUG_BUSY, exp_q.size());
    end
    tick();
  endtask

  task automatic set_addr(input logic [15:0] a);
    exp_q.push_back(8'hCC);
    send_byte(8'hCC);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    wait_idle("set_addr_helper");
  endtask

  task automatic test_reset;
    RESETN = 1'b0;
    tick(); tick();
    @(negedge CLK);
    total++;
    if ({RX_READY, TX_VALID, TX_DATA, DEBUG_BUSY, DEBUG_EXEC, DEBUG_OP, DEBUG_ARGX, DEBUG_ADDR, DEBUG_WDATA}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000}) begin
      bad++;
      $display("FAIL reset_state rdy=%0b tv=%0b op=%h addr=%h exp rdy=1 tv=0 op=0 addr=0",
               RX_READY, TX_VALID, DEBUG_OP, DEBUG_ADDR);
    end
    tick();
    RESETN = 1'b1;
  endtask

  task automatic test_set_addr;
    int e0 = exec_cnt;
    exp_q.push_back(8'hCC);
    send_byte(8'hCC);
    send_byte(8'h34);
    send_byte(8'h12);
    @(negedge CLK);
    total++;
    if (DEBUG_ADDR !== 16'h1234) begin bad++; $display("FAIL set_addr got=%h exp=1234", DEBUG_ADDR); end
    wait_idle("set_addr");
    total++;
    if (exec_cnt != e0) begin bad++; $display("FAIL set_addr_exec got=%0d exp=%0d", exec_cnt, e0); end
  endtask

  task automatic test_rd_mem_inc;
    int e0 = exec_cnt;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    send_byte(8'h90);
    @(negedge CLK);
    total++;
    if ({DEBUG_EXEC, DEBUG_OP, DEBUG_ARGX} !== {1'b1, 4'h9, 4'h0}) begin
      bad++; $display("FAIL rd_exec exec=%0b op=%h got vs exp exec=1 op=9", DEBUG_EXEC, DEBUG_OP);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge CLK);
      total++;
      if ({DEBUG_EXEC, DEBUG_OP} !== {1'b0, 4'h9}) begin
        bad++; $display("FAIL rd_wait_op exec=%0b op=%h exp exec=0 op=9", DEBUG_EXEC, DEBUG_OP);
      end
    end
    tick();
    DEBUG_DONE = 1'b1;
    DEBUG_RDATA = 16'hBEEF;
    @(negedge CLK);
    total++;
    if (DEBUG_OP !== 4'h9) begin bad++; $display("FAIL rd_done_op got=%h exp=9", DEBUG_OP); end
    tick();
    DEBUG_DONE = 1'b0;
    DEBUG_RDATA = 16'h0000;
    @(negedge CLK);
    total++;
    if ({DEBUG_OP, DEBUG_ADDR} !== {4'h0, 16'h1235}) begin
      bad++; $display("FAIL rd_after_done op=%h addr=%h exp op=0 addr=1235", DEBUG_OP, DEBUG_ADDR);
    end
    wait_idle("rd_mem");
    total++;
    if (exec_cnt != e0 + 1) begin bad++; $display("FAIL rd_exec_count got=%0d exp=%0d", exec_cnt, e0 + 1); end
  endtask

  task automatic test_wr_mem_wrap;
    int e0;
    set_addr(16'hFFFF);
    e0 = exec_cnt;
    exp_q.push_back(8'hB0);
    send_byte(8'hB0);
    send_byte(8'hCD);
    send_byte(8'hAB);
    @(negedge CLK);
    total++;
    if ({DEBUG_EXEC, DEBUG_WDATA, DEBUG_OP} !== {1'b1, 16'hABCD, 4'hB}) begin
      bad++; $display("FAIL wr_exec exec=%0b wdata=%h op=%h exp exec=1 wdata=abcd op=b",
                      DEBUG_EXEC, DEBUG_WDATA, DEBUG_OP);
    end
    tick();
    DEBUG_DONE = 1'b1;
    tick();
    DEBUG_DONE = 1'b0;
    @(negedge CLK);
    total++;
    if (DEBUG_ADDR !== 16'h0000) begin bad++; $display("FAIL wr_wrap_addr got=%h exp=0000", DEBUG_ADDR); end
    wait_idle("wr_mem");
    total++;
    if (exec_cnt != e0 + 1) begin bad++; $display("FAIL wr_exec_count got=%0d exp=%0d", exec_cnt, e0 + 1); end
  endtask

  task automatic test_tx_backpressure;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    send_byte(8'h20);
    TX_READY = 1'b0;
    tick();
    DEBUG_DONE = 1'b1;
    DEBUG_RDATA = 16'h5AA5;
    tick();
    DEBUG_DONE = 1'b0;
    DEBUG_RDATA = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      total++;
      if ({TX_VALID, TX_DATA, RX_READY} !== {1'b1, 8'hA5, 1'b0}) begin
        bad++; $display("FAIL bp_hold tv=%0b data=%02h rdy=%0b exp tv=1 data=a5 rdy=0",
                        TX_VALID, TX_DATA, RX_READY);
      end
      tick();
    end
    TX_READY = 1'b1;
    wait_idle("backpressure");
    total++;
    if (DEBUG_ADDR !== 16'h0000) begin bad++; $display("FAIL bp_no_inc got=%h exp=0000", DEBUG_ADDR); end
  endtask

  task automatic test_reserved_none;
    int e0 = exec_cnt;
    exp_q.push_back(8'hEE);
    send_byte(8'hE0);
    wait_idle("reserved");
    exp_q.push_back(8'h00);
    send_byte(8'h00);
    wait_idle("none");
    exp_q.push_back(8'h1F);
    send_byte(8'h1F);
    wait_idle("none_inc");
    total++;
    if (exec_cnt != e0) begin bad++; $display("FAIL none_exec got=%0d exp=%0d", exec_cnt, e0); end
  endtask

  task automatic test_reset_in_wait;
    set_addr(16'h0042);
    send_byte(8'h40);
    tick();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    @(negedge CLK);
    total++;
    if ({DEBUG_BUSY, DEBUG_OP, DEBUG_ADDR, TX_VALID, RX_READY} !== {1'b0, 4'h0, 16'h0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_wait busy=%0b op=%h addr=%h tv=%0b exp busy=0 op=0 addr=0 tv=0",
                      DEBUG_BUSY, DEBUG_OP, DEBUG_ADDR, TX_VALID);
    end
    tick();
  endtask

`ifdef DEBUG_PARSER_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    exp_q.push_back(8'hEE);
    send_byte(8'h60);
    @(negedge CLK);
    while (n < 100) begin
      tick();
      @(negedge CLK);
      if (TX_VALID) break;
      n++;
    end
    total++;
    if (n != 8) begin bad++; $display("FAIL timeout_wait_cycles got=%0d exp=8", n); end
    wait_idle("timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_set_addr();
    test_rd_mem_inc();
    test_wr_mem_wrap();
    test_tx_backpressure();
    test_reserved_none();
`ifdef DEBUG_PARSER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
